// File: rtl/scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// scan_decoder_pkg
// Shared definitions for the scan decoder slice: FSM state encodings and the
// mode select constants used on the bus 'mode' signal.
// ---------------------------------------------------------------------------
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_if.sv
// ---------------------------------------------------------------------------
// scan_decoder_if
// Groups the control inputs and decoded outputs of scan_decoder.
//   enable      : 1 = block active, 0 = outputs forced inactive
//   mode        : MODE_DIRECT (decode binary_in) / MODE_SCAN (autonomous scan)
//   binary_in   : select value, direct mode only
//   dwell       : extra cycles each scan index is held
//   decoder_out : registered one-hot output (OUT_WIDTH = 2**IN_WIDTH)
//   index_out   : binary index currently decoded
//   valid       : decoder_out holds a decoded value
//   wrap        : one-cycle pulse when the scan returns to index 0
// Modports: master drives the controls, slave is the decoder itself.
// ---------------------------------------------------------------------------
interface scan_decoder_if #(
  parameter int IN_WIDTH    = 4,
  parameter int DWELL_WIDTH = 8
);

  localparam int OUT_WIDTH = 2 ** IN_WIDTH;

  logic                   enable;
  logic                   mode;
  logic [IN_WIDTH-1:0]    binary_in;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [OUT_WIDTH-1:0]   decoder_out;
  logic [IN_WIDTH-1:0]    index_out;
  logic                   valid;
  logic                   wrap;

  modport master (
    output enable, mode, binary_in, dwell,
    input  decoder_out, index_out, valid, wrap
  );

  modport slave (
    input  enable, mode, binary_in, dwell,
    output decoder_out, index_out, valid, wrap
  );

endinterface

// File: rtl/scan_decoder_onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
// Purely combinational binary to one-hot conversion.
//   binary_in  : IN_WIDTH-bit select
//   onehot_out : 2**IN_WIDTH-bit output with exactly the selected bit set
// ---------------------------------------------------------------------------
module onehot_decoder #(
  parameter int IN_WIDTH = 4
) (
  input  logic [IN_WIDTH-1:0]      binary_in,
  output logic [(2**IN_WIDTH)-1:0] onehot_out
);

  always_comb begin
    onehot_out            = '0;
    onehot_out[binary_in] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
// Registered binary-to-one-hot decoder with an autonomous scan mode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : scan_decoder_if.slave (enable, mode, binary_in, dwell in;
//           decoder_out, index_out, valid, wrap out)
// States: IDLE (outputs inactive), DIRECT (decode binary_in, latency 1),
// SCAN (step index 0..OUT_WIDTH-1, each held dwell+1 cycles).
// Configuration macro SCAN_DECODER_OUT_INV_EN: when defined, decoder_out is
// active-low (inactive = all ones) for common-anode drive.
// ---------------------------------------------------------------------------
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int IN_WIDTH    = 4,
  parameter int DWELL_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_decoder_if.slave  bus
);

  localparam int OUT_WIDTH = 2 ** IN_WIDTH;

  state_t                 state;
  logic [IN_WIDTH-1:0]    index_q;
  logic [DWELL_WIDTH-1:0] count_q;
  logic [OUT_WIDTH-1:0]   onehot_q;
  logic                   valid_q;
  logic                   wrap_q;

  logic [IN_WIDTH-1:0]    next_index;
  logic [OUT_WIDTH-1:0]   next_onehot;
  logic                   scan_stay;
  logic                   scan_advance;

  // Staying in SCAN only when we already were there; entry always restarts
  // at index 0. The index advances on the cycle its counter reaches zero.
  assign scan_stay    = bus.enable && (bus.mode == MODE_SCAN) && (state == SCAN);
  assign scan_advance = scan_stay && (count_q == '0);

  // Index that will be shown next cycle; it feeds the single decoder so the
  // registered one-hot always matches the registered index.
  always_comb begin
    next_index = '0;
    if (bus.enable && (bus.mode == MODE_DIRECT)) begin
      next_index = bus.binary_in;
    end else if (scan_advance) begin
      next_index = index_q + 1'b1;
    end else if (scan_stay) begin
      next_index = index_q;
    end
  end

  onehot_decoder #(
    .IN_WIDTH (IN_WIDTH)
  ) u_onehot (
    .binary_in  (next_index),
    .onehot_out (next_onehot)
  );

  // Single-process FSM with registered outputs. Leaving SCAN for IDLE or
  // DIRECT clears the counter so a later return starts from a clean load.
  // wrap is raised only when the last index expires, never on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      index_q  <= '0;
      count_q  <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (!bus.enable) begin
      state    <= IDLE;
      index_q  <= '0;
      count_q  <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (bus.mode == MODE_DIRECT) begin
      state    <= DIRECT;
      index_q  <= next_index;
      count_q  <= '0;
      onehot_q <= next_onehot;
      valid_q  <= 1'b1;
      wrap_q   <= 1'b0;
    end else begin
      state    <= SCAN;
      index_q  <= next_index;
      onehot_q <= next_onehot;
      valid_q  <= 1'b1;
      if (state != SCAN) begin
        count_q <= bus.dwell;
        wrap_q  <= 1'b0;
      end else if (count_q == '0) begin
        count_q <= bus.dwell;
        wrap_q  <= &index_q;
      end else begin
        count_q <= count_q - 1'b1;
        wrap_q  <= 1'b0;
      end
    end
  end

`ifdef SCAN_DECODER_OUT_INV_EN
  assign bus.decoder_out = ~onehot_q;
`else
  assign bus.decoder_out = onehot_q;
`endif

  assign bus.index_out = index_q;
  assign bus.valid     = valid_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder
// Self-checking bench for scan_decoder (IN_WIDTH=4, DWELL_WIDTH=8): direct
// decode table, dwell=0 scan with wrap, dwell=3 with mid-scan dwell change,
// disable/re-enable, maximum dwell hold, and asynchronous reset mid-scan.
// Honours SCAN_DECODER_OUT_INV_EN for the expected decoder_out polarity.
// ---------------------------------------------------------------------------
module tb_scan_decoder;

  logic clk;
  logic rst_n;

  scan_decoder_if #(.IN_WIDTH(4), .DWELL_WIDTH(8)) bus ();

  scan_decoder #(
    .IN_WIDTH    (4),
    .DWELL_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  bin;
    logic [15:0] dec;
  } dvec_t;

  dvec_t vecs [16];
  int    check_count;
  int    pass_count;

  // Active-high expectation converted to the polarity of the build.
  function automatic logic [15:0] dec_exp(input logic [15:0] active);
`ifdef SCAN_DECODER_OUT_INV_EN
    return ~active;
`else
    return active;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic md,
                                input logic [3:0] bin, input logic [7:0] dw);
    bus.enable    = en;
    bus.mode      = md;
    bus.binary_in = bin;
    bus.dwell     = dw;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Checks index, one-hot output, valid and wrap for one scan cycle.
  task automatic check_scan(input string name, input int idx, input logic w);
    logic [15:0] one;
    one = 16'h0001 << idx;
    check_output({name, " index"}, 32'(bus.index_out), 32'(idx));
    check_output({name, " decoder"}, 32'(bus.decoder_out), 32'(dec_exp(one)));
    check_output({name, " valid"}, 32'(bus.valid), 32'd1);
    check_output({name, " wrap"}, 32'(bus.wrap), 32'(w));
  endtask

  task automatic check_idle(input string name);
    check_output({name, " decoder"}, 32'(bus.decoder_out), 32'(dec_exp(16'h0000)));
    check_output({name, " index"}, 32'(bus.index_out), 32'd0);
    check_output({name, " valid"}, 32'(bus.valid), 32'd0);
    check_output({name, " wrap"}, 32'(bus.wrap), 32'd0);
  endtask

  initial begin
    int cycles;
    check_count = 0;
    pass_count  = 0;

    vecs[0]  = '{4'h0, 16'h0001};
    vecs[1]  = '{4'h1, 16'h0002};
    vecs[2]  = '{4'h2, 16'h0004};
    vecs[3]  = '{4'h3, 16'h0008};
    vecs[4]  = '{4'h4, 16'h0010};
    vecs[5]  = '{4'h5, 16'h0020};
    vecs[6]  = '{4'h6, 16'h0040};
    vecs[7]  = '{4'h7, 16'h0080};
    vecs[8]  = '{4'h8, 16'h0100};
    vecs[9]  = '{4'h9, 16'h0200};
    vecs[10] = '{4'hA, 16'h0400};
    vecs[11] = '{4'hB, 16'h0800};
    vecs[12] = '{4'hC, 16'h1000};
    vecs[13] = '{4'hD, 16'h2000};
    vecs[14] = '{4'hE, 16'h4000};
    vecs[15] = '{4'hF, 16'h8000};

    rst_n = 1'b0;
    apply_stimulus(1'b1, 1'b0, 4'h5, 8'd0);
    #1;
    check_idle("reset");
    tick();
    check_idle("reset held");
    rst_n = 1'b1;

    // Direct decode table, latency one cycle.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 1'b0, vecs[i].bin, 8'd0);
      tick();
      check_output($sformatf("direct %0d decoder", i), 32'(bus.decoder_out),
                   32'(dec_exp(vecs[i].dec)));
      check_output($sformatf("direct %0d index", i), 32'(bus.index_out), 32'(vecs[i].bin));
      check_output($sformatf("direct %0d valid", i), 32'(bus.valid), 32'd1);
    end

    // Maximum dwell: index 0 must be shown for 256 cycles.
    apply_stimulus(1'b1, 1'b1, 4'h0, 8'd255);
    tick();
    check_scan("dwell255 entry", 0, 1'b0);
    cycles = 1;
    while (bus.index_out == 4'd0 && cycles < 400) begin
      tick();
      cycles++;
    end
    check_output("dwell255 hold cycles", 32'(cycles - 1), 32'd256);
    check_output("dwell255 next index", 32'(bus.index_out), 32'd1);

    // Leave SCAN through DIRECT, then rescan with dwell=0.
    apply_stimulus(1'b1, 1'b0, 4'h2, 8'd0);
    tick();
    check_output("direct after scan index", 32'(bus.index_out), 32'd2);
    apply_stimulus(1'b1, 1'b1, 4'h9, 8'd0);
    tick();
    check_scan("dwell0 entry", 0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check_scan($sformatf("dwell0 step %0d", i), i, 1'b0);
    end
    tick();
    check_scan("dwell0 wrap", 0, 1'b1);
    tick();
    check_scan("dwell0 after wrap", 1, 1'b0);

    // dwell=3, change to 0 during index 5.
    apply_stimulus(1'b1, 1'b0, 4'h0, 8'd3);
    tick();
    apply_stimulus(1'b1, 1'b1, 4'h0, 8'd3);
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check_scan($sformatf("dwell3 idx%0d c%0d", i, c), i, 1'b0);
        if (i == 5 && c == 0) bus.dwell = 8'd0;
      end
    end
    for (int i = 6; i < 10; i++) begin
      tick();
      check_scan($sformatf("dwell change idx%0d", i), i, 1'b0);
    end

    // At index 9: disable and switch mode together.
    apply_stimulus(1'b0, 1'b0, 4'h3, 8'd0);
    tick();
    check_idle("disable");
    apply_stimulus(1'b1, 1'b1, 4'h3, 8'd0);
    tick();
    check_scan("reenable", 0, 1'b0);

    // Advance to index 7, then asynchronous reset between edges.
    for (int i = 1; i < 8; i++) tick();
    check_scan("pre-reset", 7, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async reset");
    #3;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 4'h3, 8'd0);
    tick();
    check_output("post reset decoder", 32'(bus.decoder_out), 32'(dec_exp(16'h0008)));
    check_output("post reset valid", 32'(bus.valid), 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
